// File: rtl/fifo_rd_packetizer.sv
// fifo_rd_packetizer: pops the async FIFO read side and re-emits words as
// PKT_LEN-beat valid/ready packets, closing a packet early after TIMEOUT idle cycles.
module fifo_rd_packetizer #(
   parameter int WIDTH   = 16,
   parameter int PKT_LEN = 4,
   parameter int TIMEOUT = 15,
   parameter int CNT_W   = 16
) (
   input  logic             CLK_R,
   input  logic             rst,
   input  logic             fifo_empty,
   input  logic [WIDTH-1:0] fifo_dout,
   output logic             fifo_rd_en,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_data,
   output logic             m_last,
   output logic [CNT_W-1:0] pkt_count
);

   localparam int BW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
   localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [BW-1:0] BEAT_MAX = BW'(PKT_LEN - 1);
   localparam logic [TW-1:0] IDLE_MAX = TW'(TIMEOUT);

   logic             head_ok_q;
   logic             h_vld_q, h_vld_d;
   logic [WIDTH-1:0] h_data_q, h_data_d;
   logic             o_vld_q, o_vld_d;
   logic [WIDTH-1:0] o_data_q, o_data_d;
   logic             o_last_q, o_last_d;
   logic [TW-1:0]    idle_q, idle_d;
   logic [BW-1:0]    beat_q, beat_d;
   logic [CNT_W-1:0] pkt_q, pkt_d;

   logic o_free, pop, beat_last, timeout_hit, h_move, mv_last;

   always_comb begin
      o_free      = !o_vld_q || m_ready;
      // fifo_dout is trusted only once empty has been low for a full cycle
      pop         = head_ok_q && !fifo_empty && (!h_vld_q || o_free);
      beat_last   = (beat_q == BEAT_MAX);
      timeout_hit = (TIMEOUT != 0) && (idle_q == IDLE_MAX);
      h_move      = h_vld_q && o_free && (pop || beat_last || timeout_hit);
      // a word displaced by a fresh pop is never closed by the timeout
      mv_last     = beat_last || (timeout_hit && !pop);

      h_vld_d  = pop || (h_vld_q && !h_move);
      h_data_d = pop ? fifo_dout : h_data_q;
      o_vld_d  = h_move || (o_vld_q && !m_ready);
      o_data_d = h_move ? h_data_q : o_data_q;
      o_last_d = h_move ? mv_last : o_last_q;

      beat_d = beat_q;
      if (h_move) begin
         beat_d = mv_last ? '0 : beat_q + BW'(1);
      end

      idle_d = '0;
      if (!pop && h_vld_q && !h_move) begin
         idle_d = (idle_q == IDLE_MAX) ? idle_q : idle_q + TW'(1);
      end

      pkt_d = pkt_q;
      if (o_vld_q && m_ready && o_last_q) begin
         pkt_d = pkt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge CLK_R or posedge rst) begin
      if (rst) begin
         head_ok_q <= 1'b0;
         h_vld_q   <= 1'b0;
         h_data_q  <= '0;
         o_vld_q   <= 1'b0;
         o_data_q  <= '0;
         o_last_q  <= 1'b0;
         idle_q    <= '0;
         beat_q    <= '0;
         pkt_q     <= '0;
      end else begin
         head_ok_q <= !fifo_empty;
         h_vld_q   <= h_vld_d;
         h_data_q  <= h_data_d;
         o_vld_q   <= o_vld_d;
         o_data_q  <= o_data_d;
         o_last_q  <= o_last_d;
         idle_q    <= idle_d;
         beat_q    <= beat_d;
         pkt_q     <= pkt_d;
      end
   end

   assign fifo_rd_en = pop;
   assign m_valid    = o_vld_q;
   assign m_data     = o_data_q;
   assign m_last     = o_last_q;
   assign pkt_count  = pkt_q;

endmodule
